// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the two-requester shared-register arbiter.
package reg_share_arbiter_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    HOLD = 2'b10
  } state_t;

  // Requester indices (also the mux select value for each requester)
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Default parameterisation
  localparam int unsigned DEF_W        = 4;
  localparam int unsigned DEF_HOLD_MAX = 8;

  // Index of the requester that is not k
  function automatic logic other(input logic k);
    return (k == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_share_reg.sv
// Shared W-bit register with a 2:1 input mux and load enable.
module share_reg
  import reg_share_arbiter_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         c,
  input  logic         re,
  input  logic         ld,
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] q
);

  // Capture the selected data word on the falling edge whenever ld is high
  always_ff @(negedge c or posedge re) begin
    if (re) begin
      q <= '0;
    end else if (ld) begin
      q <= (sel == REQ1) ? d1 : d0;
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and load sequencer for one shared register.
// The FSM owns grants, mux select, load enable, timeout and the
// round-robin pointer; the datapath lives in share_reg.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic         c,
  input  logic         re,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic         ld,
  output logic [W-1:0] q,
  output logic         tmo
);

  localparam int unsigned   CW      = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

  state_t        state;
  logic          ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          pick;
  logic          own_req;
  logic          oth_req;

  // Winner selection from IDLE, owner/other request views, saturating count
  always_comb begin
    pick    = REQ0;
    own_req = 1'b0;
    oth_req = 1'b0;
    cnt_nxt = cnt;
    if (req0 && req1) begin
      pick = ptr;
    end else if (req1) begin
      pick = REQ1;
    end
    // sel always names the current owner while a grant is held
    own_req = (sel == REQ1) ? req1 : req0;
    oth_req = (sel == REQ1) ? req0 : req1;
    if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Sequencer FSM with registered grant, select, load and timeout outputs
  always_ff @(negedge c or posedge re) begin
    if (re) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= REQ0;
      ld    <= 1'b0;
      tmo   <= 1'b0;
      ptr   <= REQ0;
      cnt   <= '0;
    end else begin
      tmo <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            state <= LOAD;
            gnt0  <= (pick == REQ0);
            gnt1  <= (pick == REQ1);
            sel   <= pick;
            ld    <= 1'b1;
            cnt   <= '0;
          end
        end
        LOAD: begin
          // Load completes here regardless of the owner's request level
          state <= HOLD;
          ld    <= 1'b0;
          cnt   <= '0;
        end
        HOLD: begin
          if (!own_req || (cnt_nxt == CNT_MAX)) begin
            // Normal release and timeout share one path; tmo only when
            // the owner was still requesting
            tmo <= own_req;
            ptr <= other(sel);
            cnt <= '0;
            if (oth_req) begin
              state <= LOAD;
              gnt0  <= (other(sel) == REQ0);
              gnt1  <= (other(sel) == REQ1);
              sel   <= other(sel);
              ld    <= 1'b1;
            end else begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          ld    <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  share_reg #(
    .W(W)
  ) u_share_reg (
    .c  (c),
    .re (re),
    .ld (ld),
    .sel(sel),
    .d0 (d0),
    .d1 (d1),
    .q  (q)
  );

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Two-requester round-robin arbiter and sequencer for one shared W-bit register (load-enable register fed through a 2:1 data mux). It grants exclusive ownership to one requester, drives the mux select and load enable for exactly one load cycle, then holds the grant until release or timeout. It sits between two producer blocks and the shared register/mux datapath built from the team's gate-level cells.

## Interface
- W, 4, data width of the shared register and both request data buses
- HOLD_MAX, 8, maximum HOLD cycles before forced release; range 1..255
- c  in  1  clock; all state updates on the falling edge of c (matches the team's existing flip-flops)
- re  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 request; level, held until done
- req1  in  1  requester 1 request
- d0  in  W  requester 0 write data; must be stable while gnt0 is high
- d1  in  W  requester 1 write data
- gnt0  out  1  grant to requester 0, registered
- gnt1  out  1  grant to requester 1, registered
- sel  out  1  mux select, 0=d0, 1=d1; registered, equals current or last owner
- ld  out  1  load enable to the shared register; high only in LOAD
- q  out  W  shared register contents
- tmo  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- States: IDLE, LOAD, HOLD. Pointer ptr holds the requester with priority on a tie.
- Reset, asynchronous: state=IDLE, gnt0=gnt1=0, sel=0, ld=0, q=0, tmo=0, ptr=0, hold counter=0.
- IDLE: with no request, stay. With one request, grant it. With both, grant ptr. Move to LOAD; set gnt_k=1 and sel=k.
- LOAD: ld=1 and the counter is cleared. At the edge, q<=d_sel and the state moves to HOLD. The load completes even if the owner drops its request during LOAD.
- HOLD: ld=0 and the counter increments each cycle.
  - Owner request low: release. ptr<=other requester. If the other request is high, go straight to LOAD for it, with gnt handover in the same edge and no idle cycle. Otherwise go to IDLE with both grants low.
  - Counter reaches HOLD_MAX with the owner request still high: forced release, tmo=1 for one cycle, ptr<=other. Next state follows the same rule as a normal release.
  - A revoked requester still holding its request is granted again only after the other side is served, or from IDLE if the other side is idle.
- gnt0 and gnt1 are never both high. The sel value is kept after release.
- Mid-operation reset clears everything immediately. q returns to 0, and any load in progress is lost.

## Timing
- Request to grant: 1 edge. A request sampled high at edge N gives gnt high after N.
- Grant to data in q: 1 further edge. q is valid after edge N+1.
- Release latency: the owner drops its request, and gnt falls on the next edge.
- Back-to-back handover: the new owner's gnt rises on the same edge the old one falls, and its ld cycle follows immediately.
- Timeout: HOLD_MAX HOLD cycles after LOAD. tmo rises on the revoking edge and clears on the next edge.
- Counter width: ceil(log2(HOLD_MAX+1)). The counter saturates, never wraps.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'b00, LOAD=2'b01, HOLD=2'b10)
  - requester index constants
  - default W and HOLD_MAX
- Sub-module share_reg: W-bit register with async reset, load enable and 2:1 input mux on sel. The arbiter holds the FSM, ptr, counter and grants only.

## Test plan
- Reset mid-HOLD with q=4'hA: assert re asynchronously between edges -> gnt0=gnt1=0, q=0, ptr=0 immediately, no clock edge needed.
- Single request: req0=1, d0=4'h5 -> gnt0 after 1 edge, ld high for exactly 1 cycle, q=4'h5 after 2 edges. Drop req0 -> gnt0 low next edge.
- Simultaneous requests from reset, d0=4'h3, d1=4'hC -> req0 granted first (ptr=0). On release, gnt1 rises on the same edge and q=4'hC one edge later. On the next tie, req0 wins again.
- Timeout with HOLD_MAX=3: req1 held high -> gnt1 revoked 3 HOLD cycles after LOAD, one tmo pulse. With req0 pending, gnt0 is granted on the same edge.
- Owner drops its request during LOAD: q still captures d_sel, HOLD lasts one cycle, then IDLE.
- Both grants are never high together, checked across 1000 random req patterns.
